// File: rtl/shift_add_multiplier_nbit_if.sv
// Handshake/operand bundle for the sequential shift-and-add multiplier.
// Carries signed_op only when SHIFT_MULT_SIGNED_EN is defined.
interface shift_add_multiplier_nbit_if #(
    parameter int N = 4
);
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
`ifdef SHIFT_MULT_SIGNED_EN
    logic           signed_op;
`endif
    logic           busy;
    logic           done;
    logic [2*N-1:0] P;

    // start is a request honoured only while busy is low; done is a one-cycle
    // pulse with P valid in that cycle; busy and done are never high together.
`ifdef SHIFT_MULT_SIGNED_EN
    modport master (output start, A, B, signed_op, input busy, done, P);
    modport slave  (input start, A, B, signed_op, output busy, done, P);
`else
    modport master (output start, A, B, input busy, done, P);
    modport slave  (input start, A, B, output busy, done, P);
`endif
endinterface

// File: rtl/shift_add_multiplier_nbit.sv
// Sequential N x N shift-and-add multiplier, one multiplier bit per clock.
// Define SHIFT_MULT_SIGNED_EN to add two's-complement operation via signed_op.
module shift_add_multiplier_nbit #(
    parameter int N = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    shift_add_multiplier_nbit_if.slave    bus,
    output logic [1:0]                    dbg_state
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t         state, state_d;
    logic           accept, finish, busy_c, done_c;
    logic [2*N-1:0] acc, mcand, p_q, acc_sum, result;
    logic [N-1:0]   mplier, a_ld, b_ld;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        finish  = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt == CW'(1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                // A start seen in DONE launches the next operation with no idle gap.
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_sum = acc + (mplier[0] ? mcand : '0);

`ifdef SHIFT_MULT_SIGNED_EN
    logic neg_q, neg_ld;

    // Magnitudes feed the unsigned core; -2^(N-1) maps to 2^(N-1) as N-bit unsigned.
    always_comb begin
        a_ld   = (bus.signed_op && bus.A[N-1]) ? -bus.A : bus.A;
        b_ld   = (bus.signed_op && bus.B[N-1]) ? -bus.B : bus.B;
        neg_ld = bus.signed_op & (bus.A[N-1] ^ bus.B[N-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      neg_q <= 1'b0;
        else if (accept) neg_q <= neg_ld;
    end

    assign result = neg_q ? -acc_sum : acc_sum;
`else
    assign a_ld   = bus.A;
    assign b_ld   = bus.B;
    assign result = acc_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            p_q    <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, a_ld};
            mplier <= b_ld;
            cnt    <= CW'(N);
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (finish) p_q <= result;
        end
    end

    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.P     = p_q;
    assign dbg_state = state;
endmodule

// File: tb/tb_shift_add_multiplier_nbit.sv
// Directed and randomized bench for shift_add_multiplier_nbit against an arithmetic model.
// Signed cases run only when SHIFT_MULT_SIGNED_EN is defined.
module tb_shift_add_multiplier_nbit;
    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    logic [2*N-1:0] exp_q[$];

    shift_add_multiplier_nbit_if #(.N(N)) bus ();

    shift_add_multiplier_nbit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // Reference: plain integer multiply, operands read as signed when requested.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic s);
        longint x, y, prod;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        prod = x * y;
        return prod[2*N-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL spurious_done observed P=%0h expected no done", bus.P);
            end else begin
                check("scoreboard_P", 64'(bus.P), 64'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic drive_req(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
`ifdef SHIFT_MULT_SIGNED_EN
        bus.signed_op = s;
`endif
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input string tag);
        logic [2*N-1:0] e;
        e = ref_mul(a, b, s);
        @(negedge clk);
        drive_req(a, b, s);
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = N'($urandom);
        bus.B     = N'($urandom);
        check({tag, "_busy1"}, 64'({bus.busy, bus.done}), 64'(2'b10));
        for (int k = 2; k <= N; k++) begin
            @(negedge clk);
            check({tag, "_busyN"}, 64'({bus.busy, bus.done}), 64'(2'b10));
        end
        @(negedge clk);
        check({tag, "_done"}, 64'({bus.busy, bus.done}), 64'(2'b01));
        check({tag, "_P"}, 64'(bus.P), 64'(e));
        @(negedge clk);
        check({tag, "_after"}, 64'({bus.busy, bus.done}), 64'(2'b00));
        check({tag, "_hold"}, 64'(bus.P), 64'(e));
    endtask

    initial begin
        int base;
        logic [N-1:0] ra, rb;
        logic rs;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
`ifdef SHIFT_MULT_SIGNED_EN
        bus.signed_op = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_busy_done", 64'({bus.busy, bus.done}), 64'(2'b00));
        check("reset_P", 64'(bus.P), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic products, zero operand keeps full latency
        run_op(4'd3,  4'd5,  1'b0, "op_3x5");
        run_op(4'd15, 4'd15, 1'b0, "op_15x15");
        run_op(4'd0,  4'd15, 1'b0, "op_0x15");
        run_op(4'd9,  4'd9,  1'b0, "op_9x9");
        check("const_3x5", 64'(ref_mul(4'd3, 4'd5, 1'b0)), 64'h0F);

        // start during busy is ignored
        base = done_cnt;
        @(negedge clk);
        drive_req(4'd10, 4'd3, 1'b0);
        @(posedge clk);
        exp_q.push_back(ref_mul(4'd10, 4'd3, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive_req(4'd7, 4'd7, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ignore_done_c5", 64'(bus.done), 64'(1));
        check("ignore_P", 64'(bus.P), 64'h1E);
        repeat (8) @(negedge clk);
        check("ignore_single_done", 64'(done_cnt - base), 64'(1));

        // Back-to-back with start held high
        @(negedge clk);
        drive_req(4'd2, 4'd3, 1'b0);
        @(posedge clk);
        exp_q.push_back(8'h06);
        @(negedge clk);
        bus.A = 4'd4;
        bus.B = 4'd4;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("b2b_done1", 64'({bus.busy, bus.done}), 64'(2'b01));
        check("b2b_P1", 64'(bus.P), 64'h06);
        @(posedge clk);
        exp_q.push_back(8'h10);
        @(negedge clk);
        check("b2b_rerun", 64'({bus.busy, bus.done}), 64'(2'b10));
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("b2b_done2", 64'({bus.busy, bus.done}), 64'(2'b01));
        check("b2b_P2", 64'(bus.P), 64'h10);
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b_idle", 64'({bus.busy, bus.done}), 64'(2'b00));

        // Asynchronous reset mid-operation
        @(negedge clk);
        drive_req(4'd15, 4'd15, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst_mid_busy_done", 64'({bus.busy, bus.done}), 64'(2'b00));
        check("rst_mid_P", 64'(bus.P), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt;
        repeat (10) @(negedge clk);
        check("rst_no_done", 64'(done_cnt - base), 64'(0));
        check("rst_P_still0", 64'(bus.P), 64'(0));

`ifdef SHIFT_MULT_SIGNED_EN
        run_op(4'h8, 4'h8, 1'b1, "s_m8xm8");
        check("s_m8xm8_lit", 64'(bus.P), 64'h40);
        run_op(4'hD, 4'd5, 1'b1, "s_m3x5");
        check("s_m3x5_lit", 64'(bus.P), 64'hF1);
        run_op(4'hD, 4'd5, 1'b0, "u_13x5");
        check("u_13x5_lit", 64'(bus.P), 64'h41);
`endif

        // Randomized operands against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
`ifdef SHIFT_MULT_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
